// File: rtl/ps2_key_pkg.sv
// Shared scancode map, direction encoding and event decode for the PS/2 key scheduler.
package ps2_key_pkg;

    localparam int EXP_BIT = 9;
    localparam int BRK_BIT = 8;

    localparam logic [7:0] SC_W         = 8'h1D;
    localparam logic [7:0] SC_S         = 8'h1B;
    localparam logic [7:0] SC_A         = 8'h1C;
    localparam logic [7:0] SC_D         = 8'h23;
    localparam logic [7:0] SC_SPACE     = 8'h29;
    localparam logic [7:0] SC_UP_EXT    = 8'h75;
    localparam logic [7:0] SC_DOWN_EXT  = 8'h72;
    localparam logic [7:0] SC_LEFT_EXT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT_EXT = 8'h74;
    localparam logic [7:0] SC_ENTER     = 8'h5A;
    localparam logic [7:0] SC_ESC       = 8'h76;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    typedef enum logic [1:0] {
        ROLE_NONE,
        ROLE_DIR,
        ROLE_FIRE,
        ROLE_PAUSE
    } key_role_e;

    typedef struct packed {
        logic      p2;
        key_role_e role;
        logic [1:0] dir;
        logic      brk;
    } key_ev_t;

    function automatic key_ev_t decode_key(input logic [9:0] code);
        key_ev_t ev;
        ev.p2   = 1'b0;
        ev.role = ROLE_NONE;
        ev.dir  = DIR_UP;
        ev.brk  = code[BRK_BIT];
        if (!code[EXP_BIT]) begin
            case (code[7:0])
                SC_W:     begin ev.role = ROLE_DIR;  ev.dir = DIR_UP;    end
                SC_S:     begin ev.role = ROLE_DIR;  ev.dir = DIR_DOWN;  end
                SC_A:     begin ev.role = ROLE_DIR;  ev.dir = DIR_LEFT;  end
                SC_D:     begin ev.role = ROLE_DIR;  ev.dir = DIR_RIGHT; end
                SC_SPACE: ev.role = ROLE_FIRE;
                SC_ENTER: begin ev.role = ROLE_FIRE; ev.p2 = 1'b1; end
                SC_ESC:   ev.role = ROLE_PAUSE;
                default:  ev.role = ROLE_NONE;
            endcase
        end else begin
            case (code[7:0])
                SC_UP_EXT:    begin ev.role = ROLE_DIR; ev.dir = DIR_UP;    ev.p2 = 1'b1; end
                SC_DOWN_EXT:  begin ev.role = ROLE_DIR; ev.dir = DIR_DOWN;  ev.p2 = 1'b1; end
                SC_LEFT_EXT:  begin ev.role = ROLE_DIR; ev.dir = DIR_LEFT;  ev.p2 = 1'b1; end
                SC_RIGHT_EXT: begin ev.role = ROLE_DIR; ev.dir = DIR_RIGHT; ev.p2 = 1'b1; end
                default:      ev.role = ROLE_NONE;
            endcase
        end
        return ev;
    endfunction

    // Highest-priority held direction; keeps the current one when nothing is held.
    function automatic logic [1:0] fallback_dir(input logic [3:0] held, input logic [1:0] cur);
        if (held[DIR_UP])         return DIR_UP;
        else if (held[DIR_DOWN])  return DIR_DOWN;
        else if (held[DIR_LEFT])  return DIR_LEFT;
        else if (held[DIR_RIGHT]) return DIR_RIGHT;
        else                      return cur;
    endfunction

endpackage

// File: rtl/ps2_player_ctrl.sv
// Per-player held-key tracking, last-pressed direction arbitration, move cadence and fire cooldown.
module ps2_player_ctrl
    import ps2_key_pkg::*;
#(
    parameter int MOVE_PERIOD   = 100000,
    parameter int FIRE_COOLDOWN = 500000,
    parameter int CNT_W         = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       dir_ev,
    input  logic [1:0] dir_idx,
    input  logic       fire_ev,
    input  logic       brk,
    input  logic       pause,
    output logic [1:0] dir,
    output logic       dir_vld,
    output logic       move,
    output logic       fire
);

    localparam logic [CNT_W-1:0] MOVE_RELOAD = CNT_W'(MOVE_PERIOD - 1);
    localparam logic [CNT_W-1:0] COOL_LOAD   = CNT_W'(FIRE_COOLDOWN);
    localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);

    logic [3:0]       held, held_n;
    logic             fire_held, fire_held_n;
    logic [1:0]       dir_n;
    logic             vld_n, move_n, fire_n;
    logic [CNT_W-1:0] move_cnt, move_cnt_n;
    logic [CNT_W-1:0] cool_cnt, cool_cnt_n;

    always_comb begin
        held_n = held;
        dir_n  = dir;
        if (dir_ev) held_n[dir_idx] = ~brk;
        if (dir_ev && !brk && !held[dir_idx])
            dir_n = dir_idx;
        else if (dir_ev && brk && held[dir_idx] && (dir_idx == dir))
            dir_n = fallback_dir(held_n, dir);
        vld_n = |held_n;
    end

    // A fresh press and counter expiry share one reload, so they never double-pulse.
    always_comb begin
        move_cnt_n = move_cnt;
        move_n     = 1'b0;
        if (!vld_n) begin
            move_cnt_n = '0;
        end else if (!pause) begin
            if (!dir_vld || (move_cnt == '0)) begin
                move_n     = 1'b1;
                move_cnt_n = MOVE_RELOAD;
            end else begin
                move_cnt_n = move_cnt - ONE;
            end
        end
    end

    always_comb begin
        fire_held_n = fire_ev ? ~brk : fire_held;
        fire_n      = fire_ev && !brk && !fire_held && (cool_cnt == '0) && !pause;
        cool_cnt_n  = cool_cnt;
        if (fire_n)
            cool_cnt_n = COOL_LOAD;
        else if (!pause && (cool_cnt != '0))
            cool_cnt_n = cool_cnt - ONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held      <= '0;
            fire_held <= 1'b0;
            dir       <= DIR_UP;
            dir_vld   <= 1'b0;
            move      <= 1'b0;
            fire      <= 1'b0;
            move_cnt  <= '0;
            cool_cnt  <= '0;
        end else begin
            held      <= held_n;
            fire_held <= fire_held_n;
            dir       <= dir_n;
            dir_vld   <= vld_n;
            move      <= move_n;
            fire      <= fire_n;
            move_cnt  <= move_cnt_n;
            cool_cnt  <= cool_cnt_n;
        end
    end

endmodule

// File: rtl/ps2_key_scheduler.sv
// Decodes PS/2 key events, owns the pause toggle, and routes key events to two player controllers.
module ps2_key_scheduler
    import ps2_key_pkg::*;
#(
    parameter int MOVE_PERIOD   = 100000,
    parameter int FIRE_COOLDOWN = 500000,
    parameter int CNT_W         = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [9:0] key_code,
    output logic [1:0] p1_dir,
    output logic       p1_dir_vld,
    output logic       p1_move,
    output logic       p1_fire,
    output logic [1:0] p2_dir,
    output logic       p2_dir_vld,
    output logic       p2_move,
    output logic       p2_fire,
    output logic       pause
);

    key_ev_t ev;
    logic    esc_ev, esc_held, pause_n;
    logic    p1_dir_ev, p1_fire_ev, p2_dir_ev, p2_fire_ev;

    always_comb begin
        ev         = decode_key(key_code);
        esc_ev     = key_valid && (ev.role == ROLE_PAUSE);
        p1_dir_ev  = key_valid && (ev.role == ROLE_DIR)  && !ev.p2;
        p2_dir_ev  = key_valid && (ev.role == ROLE_DIR)  &&  ev.p2;
        p1_fire_ev = key_valid && (ev.role == ROLE_FIRE) && !ev.p2;
        p2_fire_ev = key_valid && (ev.role == ROLE_FIRE) &&  ev.p2;
        pause_n    = pause ^ (esc_ev && !ev.brk && !esc_held);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pause    <= 1'b0;
            esc_held <= 1'b0;
        end else begin
            pause <= pause_n;
            if (esc_ev) esc_held <= ~ev.brk;
        end
    end

    // Players see the upcoming pause value so gating lines up with the pause output.
    ps2_player_ctrl #(
        .MOVE_PERIOD  (MOVE_PERIOD),
        .FIRE_COOLDOWN(FIRE_COOLDOWN),
        .CNT_W        (CNT_W)
    ) u_p1 (
        .clk    (clk),
        .rst    (rst),
        .dir_ev (p1_dir_ev),
        .dir_idx(ev.dir),
        .fire_ev(p1_fire_ev),
        .brk    (ev.brk),
        .pause  (pause_n),
        .dir    (p1_dir),
        .dir_vld(p1_dir_vld),
        .move   (p1_move),
        .fire   (p1_fire)
    );

    ps2_player_ctrl #(
        .MOVE_PERIOD  (MOVE_PERIOD),
        .FIRE_COOLDOWN(FIRE_COOLDOWN),
        .CNT_W        (CNT_W)
    ) u_p2 (
        .clk    (clk),
        .rst    (rst),
        .dir_ev (p2_dir_ev),
        .dir_idx(ev.dir),
        .fire_ev(p2_fire_ev),
        .brk    (ev.brk),
        .pause  (pause_n),
        .dir    (p2_dir),
        .dir_vld(p2_dir_vld),
        .move   (p2_move),
        .fire   (p2_fire)
    );

endmodule

// File: tb/tb_ps2_key_scheduler.sv
// Directed vector table plus randomized events against a time-based reference model.
module tb_ps2_key_scheduler;

    localparam int MP = 8;
    localparam int FC = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_valid = 1'b0;
    logic [9:0] key_code = '0;
    logic [1:0] p1_dir, p2_dir;
    logic       p1_dir_vld, p1_move, p1_fire, p2_dir_vld, p2_move, p2_fire, pause;
    logic [10:0] dut_vec;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ps2_key_scheduler #(.MOVE_PERIOD(MP), .FIRE_COOLDOWN(FC), .CNT_W(20)) dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
        .p1_dir(p1_dir), .p1_dir_vld(p1_dir_vld), .p1_move(p1_move), .p1_fire(p1_fire),
        .p2_dir(p2_dir), .p2_dir_vld(p2_dir_vld), .p2_move(p2_move), .p2_fire(p2_fire),
        .pause(pause)
    );

    assign dut_vec = {p1_dir, p1_dir_vld, p1_move, p1_fire,
                      p2_dir, p2_dir_vld, p2_move, p2_fire, pause};

    // Reference model: held sets, last-pressed direction, and elapsed unpaused cycles.
    bit m_held [2][4];
    int m_dir [2];
    bit m_vld [2];
    int m_age [2];
    int m_since [2];
    bit m_fire_held [2];
    bit m_move [2];
    bit m_fire [2];
    bit m_esc_held, m_pause;

    task automatic model_reset();
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 4; i++) m_held[p][i] = 0;
            m_dir[p] = 0; m_vld[p] = 0; m_age[p] = 0; m_since[p] = FC;
            m_fire_held[p] = 0; m_move[p] = 0; m_fire[p] = 0;
        end
        m_esc_held = 0; m_pause = 0;
    endtask

    task automatic model_step(input logic v, input logic [9:0] c);
        int pl, role;
        bit esc, brk, was, prev;
        pl = -1; role = -1; esc = 0; brk = c[8];
        if (v) begin
            case ({c[9], c[7:0]})
                9'h01D: begin pl = 0; role = 0; end
                9'h01B: begin pl = 0; role = 1; end
                9'h01C: begin pl = 0; role = 2; end
                9'h023: begin pl = 0; role = 3; end
                9'h029: begin pl = 0; role = 4; end
                9'h175: begin pl = 1; role = 0; end
                9'h172: begin pl = 1; role = 1; end
                9'h16B: begin pl = 1; role = 2; end
                9'h174: begin pl = 1; role = 3; end
                9'h05A: begin pl = 1; role = 4; end
                9'h076: esc = 1;
                default: ;
            endcase
        end
        if (esc) begin
            if (!brk && !m_esc_held) m_pause = !m_pause;
            m_esc_held = !brk;
        end
        for (int p = 0; p < 2; p++) begin
            prev = m_vld[p];
            m_move[p] = 0;
            m_fire[p] = 0;
            if (pl == p && role < 4) begin
                was = m_held[p][role];
                if (!brk && !was) m_dir[p] = role;
                m_held[p][role] = !brk;
                if (brk && was && m_dir[p] == role) begin
                    for (int i = 3; i >= 0; i--) if (m_held[p][i]) m_dir[p] = i;
                end
            end
            m_vld[p] = m_held[p][0] | m_held[p][1] | m_held[p][2] | m_held[p][3];
            if (!m_vld[p]) m_age[p] = 0;
            else if (!prev) begin
                if (!m_pause) begin m_move[p] = 1; m_age[p] = 0; end
                else m_age[p] = MP - 1;
            end else if (!m_pause) begin
                m_age[p]++;
                if (m_age[p] % MP == 0) m_move[p] = 1;
            end
            if (pl == p && role == 4 && !brk && !m_fire_held[p] && m_since[p] >= FC && !m_pause)
                m_fire[p] = 1;
            if (m_fire[p]) m_since[p] = 0;
            else if (!m_pause && m_since[p] < FC) m_since[p]++;
            if (pl == p && role == 4) m_fire_held[p] = !brk;
        end
    endtask

    function automatic logic [10:0] model_vec();
        return {2'(m_dir[0]), m_vld[0], m_move[0], m_fire[0],
                2'(m_dir[1]), m_vld[1], m_move[1], m_fire[1], m_pause};
    endfunction

    function automatic logic [10:0] mk(input logic [1:0] d1, input logic v1, input logic mv1,
                                       input logic f1, input logic [1:0] d2, input logic v2,
                                       input logic mv2, input logic pz);
        return {d1, v1, mv1, f1, d2, v2, mv2, 1'b0, pz};
    endfunction

    task automatic check(input string name, input logic [10:0] got, input logic [10:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, got, exp);
        end
    endtask

    task automatic step(input logic v, input logic [9:0] c);
        key_valid = v;
        key_code  = c;
        @(posedge clk);
        model_step(v, c);
        @(negedge clk);
        key_valid = 1'b0;
        check("cycle", dut_vec, model_vec());
    endtask

    task automatic async_reset();
        #2 rst = 1'b1;
        #1 check("async_reset", dut_vec, 11'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic [9:0]  code;
        logic [10:0] exp;
        int          gap;
    } vec_t;

    vec_t vecs [$];
    logic [9:0] pool [13];

    initial begin
        model_reset();
        vecs.push_back('{10'h01D, mk(0,1,1,0, 0,0,0, 0), 7});
        vecs.push_back('{10'h023, mk(3,1,1,0, 0,0,0, 0), 3});
        vecs.push_back('{10'h123, mk(0,1,0,0, 0,0,0, 0), 0});
        vecs.push_back('{10'h01D, mk(0,1,0,0, 0,0,0, 0), 0});
        vecs.push_back('{10'h01D, mk(0,1,0,0, 0,0,0, 0), 0});
        vecs.push_back('{10'h01D, mk(0,1,0,0, 0,0,0, 0), 0});
        vecs.push_back('{10'h01D, mk(0,1,1,0, 0,0,0, 0), 2});
        vecs.push_back('{10'h11D, mk(0,0,0,0, 0,0,0, 0), 10});
        vecs.push_back('{10'h029, mk(0,0,0,1, 0,0,0, 0), 0});
        vecs.push_back('{10'h129, mk(0,0,0,0, 0,0,0, 0), 3});
        vecs.push_back('{10'h029, mk(0,0,0,0, 0,0,0, 0), 0});
        vecs.push_back('{10'h129, mk(0,0,0,0, 0,0,0, 0), 13});
        vecs.push_back('{10'h029, mk(0,0,0,0, 0,0,0, 0), 0});
        vecs.push_back('{10'h129, mk(0,0,0,0, 0,0,0, 0), 0});
        vecs.push_back('{10'h029, mk(0,0,0,1, 0,0,0, 0), 0});
        vecs.push_back('{10'h129, mk(0,0,0,0, 0,0,0, 0), 0});
        vecs.push_back('{10'h076, mk(0,0,0,0, 0,0,0, 1), 0});
        vecs.push_back('{10'h275, mk(0,0,0,0, 0,1,0, 1), 5});
        vecs.push_back('{10'h176, mk(0,0,0,0, 0,1,0, 1), 0});
        vecs.push_back('{10'h076, mk(0,0,0,0, 0,1,1, 0), 3});
        vecs.push_back('{10'h015, mk(0,0,0,0, 0,1,0, 0), 0});
        vecs.push_back('{10'h115, mk(0,0,0,0, 0,1,0, 0), 0});
        vecs.push_back('{10'h375, mk(0,0,0,0, 0,0,0, 0), 2});

        pool = '{10'h01D, 10'h01B, 10'h01C, 10'h023, 10'h029, 10'h275, 10'h272,
                 10'h26B, 10'h274, 10'h05A, 10'h076, 10'h015, 10'h06B};

        repeat (3) @(negedge clk);
        check("reset_state", dut_vec, 11'd0);
        rst = 1'b0;
        for (int i = 0; i < 100; i++) step(1'b0, 10'h000);

        // Reset while W is held: the key counts as released afterwards.
        step(1'b1, 10'h01D);
        for (int i = 0; i < 3; i++) step(1'b0, 10'h000);
        async_reset();
        for (int i = 0; i < 12; i++) step(1'b0, 10'h000);

        for (int i = 0; i < vecs.size(); i++) begin
            step(1'b1, vecs[i].code);
            check($sformatf("vec%0d", i), dut_vec, vecs[i].exp);
            for (int g = 0; g < vecs[i].gap; g++) step(1'b0, 10'h000);
        end

        for (int i = 0; i < 3000; i++) begin
            logic [9:0] c;
            c = pool[$urandom_range(0, 12)];
            if ($urandom_range(0, 1) == 0) c[8] = 1'b1;
            if (i == 1500) async_reset();
            step($urandom_range(0, 2) == 0, c);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
